img_fetch_ctrl: RTL and testbench

Parametrised image-SRAM read sequencer for the Gaussian stage. On ST_GAUSSIAN it issues one row address per buffer request, for one or more octave passes: pass p reads every 2^p-th row. Read data is tagged with a valid flag, row index and pass index after a configurable SRAM latency. The block signals completion to the top-level FSM and supports abort and back-pressure.

---
 rtl/img_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_img_fetch_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/img_fetch_ctrl.sv
// ============================================================================
// img_fetch_ctrl
// ----------------------------------------------------------------------------
// Image-SRAM read sequencer for the Gaussian stage. While the top-level FSM
// sits in ST_GAUSSIAN it issues one row address per line-buffer request. It
// runs one or more octave passes, where pass p reads every 2^p-th row. Each
// issued read carries a tag (row, pass, last-of-pass) through a delay line as
// long as the SRAM read latency. The tag therefore comes out aligned with the
// read data. Once the final row of the final pass has been delivered, the
// block pulses fetch_done. It then parks until the top FSM leaves ST_GAUSSIAN.
//
// Parameters
//   ADDR_W     SRAM address width
//   NUM_ROWS   rows per frame (NUM_ROWS <= 2^ADDR_W - BASE_ADDR)
//   BASE_ADDR  SRAM address of row 0
//   PASSES     number of octave passes (1..4)
//   RD_LAT     SRAM read latency in cycles (1..3)
//
// Ports
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   state       top FSM state (0 idle, 1 gaussian, 2 detect, 3 filter,
//               4 match, 5 end)
//   buffer_req  line buffer can take one row this cycle
//   sram_cs     SRAM read strobe, one cycle per issued row
//   addr        SRAM row address, valid with sram_cs
//   img_valid   read data for a tagged row is on the SRAM bus
//   img_row     row index belonging to the data under img_valid
//   img_pass    pass index belonging to the data under img_valid
//   img_last    with img_valid: last row of the current pass
//   fetch_done  one-cycle pulse after the final row of the final pass
// ============================================================================
module img_fetch_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int NUM_ROWS  = 480,
  parameter int BASE_ADDR = 0,
  parameter int PASSES    = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        state,
  input  logic              buffer_req,
  output logic              sram_cs,
  output logic [ADDR_W-1:0] addr,
  output logic              img_valid,
  output logic [ADDR_W-1:0] img_row,
  output logic [1:0]        img_pass,
  output logic              img_last,
  output logic              fetch_done
);

  // Top FSM encodings this block reacts to.
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_GAUSSIAN = 3'd1;
  localparam logic [2:0] ST_END      = 3'd5;

  // The row counter is one bit wider than the address. row + stride can
  // therefore never wrap before it is compared against NUM_ROWS.
  localparam logic [ADDR_W:0]   ROW_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   NUM_ROWS_W = (ADDR_W + 1)'(NUM_ROWS);
  localparam logic [ADDR_W-1:0] BASE_W     = ADDR_W'(BASE_ADDR);
  localparam logic [1:0]        LAST_PASS  = 2'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_HOLD  = 2'd3
  } fsm_t;

  fsm_t              fsm_r;
  logic [ADDR_W:0]   row_r;
  logic [1:0]        pass_r;

  // Tag delay line: stage 0 is loaded on the same edge that raises sram_cs.
  // Stage RD_LAT-1 feeds the registered img_* outputs.
  logic [RD_LAT-1:0] pipe_valid_r;
  logic [RD_LAT-1:0] pipe_last_r;
  logic [ADDR_W-1:0] pipe_row_r  [RD_LAT];
  logic [1:0]        pipe_pass_r [RD_LAT];

  logic [ADDR_W:0]   step_s;
  logic [ADDR_W:0]   row_next_s;
  logic              last_s;
  logic              final_pass_s;
  logic              gauss_s;
  logic              force_zero_s;
  logic              pipe_empty_s;

  // Next-row arithmetic, pass-boundary detection and state decode.
  always_comb begin
    step_s       = ROW_ONE << pass_r;
    row_next_s   = row_r + step_s;
    last_s       = 1'b0;
    final_pass_s = 1'b0;
    gauss_s      = 1'b0;
    force_zero_s = 1'b0;
    pipe_empty_s = 1'b0;

    if (row_next_s >= NUM_ROWS_W) begin
      last_s = 1'b1;
    end else begin
      last_s = 1'b0;
    end

    if (pass_r == LAST_PASS) begin
      final_pass_s = 1'b1;
    end else begin
      final_pass_s = 1'b0;
    end

    if (state == ST_GAUSSIAN) begin
      gauss_s = 1'b1;
    end else begin
      gauss_s = 1'b0;
    end

    if ((state == ST_IDLE) || (state == ST_END)) begin
      force_zero_s = 1'b1;
    end else begin
      force_zero_s = 1'b0;
    end

    if (pipe_valid_r == '0) begin
      pipe_empty_s = 1'b1;
    end else begin
      pipe_empty_s = 1'b0;
    end
  end

  // Sequencer FSM, tag delay line and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_r        <= S_IDLE;
      row_r        <= '0;
      pass_r       <= 2'd0;
      pipe_valid_r <= '0;
      pipe_last_r  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_row_r[i]  <= '0;
        pipe_pass_r[i] <= 2'd0;
      end
      sram_cs      <= 1'b0;
      addr         <= '0;
      img_valid    <= 1'b0;
      img_row      <= '0;
      img_pass     <= 2'd0;
      img_last     <= 1'b0;
      fetch_done   <= 1'b0;
    end else begin
      // The delay line always shifts. Stage 0 is empty unless a row issues.
      for (int i = RD_LAT - 1; i > 0; i--) begin
        pipe_valid_r[i] <= pipe_valid_r[i-1];
        pipe_last_r[i]  <= pipe_last_r[i-1];
        pipe_row_r[i]   <= pipe_row_r[i-1];
        pipe_pass_r[i]  <= pipe_pass_r[i-1];
      end
      pipe_valid_r[0] <= 1'b0;
      pipe_last_r[0]  <= 1'b0;

      // Present the oldest tag. Row and pass keep their last value between tags.
      img_valid <= pipe_valid_r[RD_LAT-1];
      img_last  <= pipe_valid_r[RD_LAT-1] & pipe_last_r[RD_LAT-1];
      if (pipe_valid_r[RD_LAT-1]) begin
        img_row  <= pipe_row_r[RD_LAT-1];
        img_pass <= pipe_pass_r[RD_LAT-1];
      end

      sram_cs    <= 1'b0;
      fetch_done <= 1'b0;

      if (force_zero_s) begin
        addr <= '0;
      end

      case (fsm_r)
        S_IDLE: begin
          if (gauss_s) begin
            fsm_r  <= S_RUN;
            row_r  <= '0;
            pass_r <= 2'd0;
          end
        end

        S_RUN: begin
          if (!gauss_s) begin
            // Abort: drop everything in flight and stay silent.
            fsm_r        <= S_IDLE;
            row_r        <= '0;
            pass_r       <= 2'd0;
            addr         <= '0;
            pipe_valid_r <= '0;
            pipe_last_r  <= '0;
            img_valid    <= 1'b0;
            img_last     <= 1'b0;
          end else if (buffer_req) begin
            sram_cs         <= 1'b1;
            addr            <= BASE_W + row_r[ADDR_W-1:0];
            pipe_valid_r[0] <= 1'b1;
            pipe_last_r[0]  <= last_s;
            pipe_row_r[0]   <= row_r[ADDR_W-1:0];
            pipe_pass_r[0]  <= pass_r;
            if (last_s) begin
              if (final_pass_s) begin
                fsm_r <= S_DRAIN;
              end else begin
                // Next pass starts right away, with no bubble cycle.
                pass_r <= pass_r + 2'd1;
                row_r  <= '0;
              end
            end else begin
              row_r <= row_next_s;
            end
          end
        end

        S_DRAIN: begin
          if (!gauss_s) begin
            fsm_r        <= S_IDLE;
            row_r        <= '0;
            pass_r       <= 2'd0;
            addr         <= '0;
            pipe_valid_r <= '0;
            pipe_last_r  <= '0;
            img_valid    <= 1'b0;
            img_last     <= 1'b0;
          end else if (pipe_empty_s) begin
            // The final tag left the delay line on the previous edge.
            fetch_done <= 1'b1;
            fsm_r      <= S_HOLD;
          end
        end

        S_HOLD: begin
          // Wait here so a lingering ST_GAUSSIAN cannot start a second frame.
          if (!gauss_s) begin
            fsm_r <= S_IDLE;
          end
        end

        default: begin
          fsm_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_fetch_ctrl.sv
module tb_img_fetch_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b1;
  logic [2:0] state_a, state_b;
  logic       req_a, req_b;

  logic       sram_cs_a, img_valid_a, img_last_a, fetch_done_a;
  logic [8:0] addr_a, img_row_a;
  logic [1:0] img_pass_a;
  logic       sram_cs_b, img_valid_b, img_last_b, fetch_done_b;
  logic [8:0] addr_b, img_row_b;
  logic [1:0] img_pass_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected issue order for 8 rows and 3 passes.
  int rows_a [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 2, 4, 6, 0, 4};
  int pass_a [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
  int last_a [14] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1};

  img_fetch_ctrl #(.ADDR_W(9), .NUM_ROWS(8), .BASE_ADDR(0), .PASSES(3), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .state(state_a), .buffer_req(req_a),
    .sram_cs(sram_cs_a), .addr(addr_a), .img_valid(img_valid_a), .img_row(img_row_a),
    .img_pass(img_pass_a), .img_last(img_last_a), .fetch_done(fetch_done_a)
  );

  img_fetch_ctrl #(.ADDR_W(9), .NUM_ROWS(8), .BASE_ADDR(32), .PASSES(1), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .state(state_b), .buffer_req(req_b),
    .sram_cs(sram_cs_b), .addr(addr_b), .img_valid(img_valid_b), .img_row(img_row_b),
    .img_pass(img_pass_b), .img_last(img_last_b), .fetch_done(fetch_done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int e_row;

  initial begin
    state_a = 3'd0; state_b = 3'd0; req_a = 1'b0; req_b = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    chk("rst_cs_a",    32'(sram_cs_a), 0);
    chk("rst_addr_a",  32'(addr_a), 0);
    chk("rst_valid_a", 32'(img_valid_a), 0);
    chk("rst_done_a",  32'(fetch_done_a), 0);
    chk("rst_cs_b",    32'(sram_cs_b), 0);
    chk("rst_row_b",   32'(img_row_b), 0);
    rst_n = 1'b1;
    tick();

    // Instance A: three passes, requests held high.
    state_a = 3'd1; req_a = 1'b1;
    tick();
    chk("a_enter_cs", 32'(sram_cs_a), 0);
    for (int i = 0; i < 14; i++) begin
      tick();
      chk("a_cs",   32'(sram_cs_a), 1);
      chk("a_addr", 32'(addr_a), rows_a[i]);
      chk("a_done", 32'(fetch_done_a), 0);
      if (i > 0) begin
        chk("a_valid", 32'(img_valid_a), 1);
        chk("a_row",   32'(img_row_a), rows_a[i-1]);
        chk("a_pass",  32'(img_pass_a), pass_a[i-1]);
        chk("a_last",  32'(img_last_a), last_a[i-1]);
      end else begin
        chk("a_valid0", 32'(img_valid_a), 0);
      end
    end
    tick();
    chk("a_drain_cs",    32'(sram_cs_a), 0);
    chk("a_drain_addr",  32'(addr_a), 4);
    chk("a_drain_valid", 32'(img_valid_a), 1);
    chk("a_drain_row",   32'(img_row_a), 4);
    chk("a_drain_pass",  32'(img_pass_a), 2);
    chk("a_drain_last",  32'(img_last_a), 1);
    chk("a_drain_done",  32'(fetch_done_a), 0);
    tick();
    chk("a_done_pulse", 32'(fetch_done_a), 1);
    chk("a_done_valid", 32'(img_valid_a), 0);
    chk("a_done_last",  32'(img_last_a), 0);

    // Hold: still ST_GAUSSIAN, no re-run.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("a_hold_cs",   32'(sram_cs_a), 0);
      chk("a_hold_done", 32'(fetch_done_a), 0);
    end
    state_a = 3'd0;
    tick();
    chk("a_idle_addr", 32'(addr_a), 0);
    state_a = 3'd1;
    tick();
    chk("a_rerun_enter_cs", 32'(sram_cs_a), 0);
    tick();
    chk("a_rerun_cs0",   32'(sram_cs_a), 1);
    chk("a_rerun_addr0", 32'(addr_a), 0);
    tick();
    chk("a_rerun_addr1", 32'(addr_a), 1);
    chk("a_rerun_row0",  32'(img_row_a), 0);
    tick();
    chk("a_rerun_addr2", 32'(addr_a), 2);
    chk("a_rerun_row1",  32'(img_row_a), 1);

    // Abort after the third issue.
    state_a = 3'd2;
    tick();
    chk("a_abort_cs",    32'(sram_cs_a), 0);
    chk("a_abort_addr",  32'(addr_a), 0);
    chk("a_abort_valid", 32'(img_valid_a), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("a_abort_cs_q",    32'(sram_cs_a), 0);
      chk("a_abort_valid_q", 32'(img_valid_a), 0);
      chk("a_abort_done_q",  32'(fetch_done_a), 0);
    end

    // Asynchronous reset in the middle of a pass.
    state_a = 3'd1;
    tick();
    tick();
    tick();
    tick();
    chk("a_pre_rst_addr", 32'(addr_a), 2);
    #3 rst_n = 1'b0;
    #1;
    chk("a_arst_cs",    32'(sram_cs_a), 0);
    chk("a_arst_addr",  32'(addr_a), 0);
    chk("a_arst_valid", 32'(img_valid_a), 0);
    chk("a_arst_row",   32'(img_row_a), 0);
    chk("a_arst_done",  32'(fetch_done_a), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("a_restart_enter_cs", 32'(sram_cs_a), 0);
    tick();
    chk("a_restart_cs",   32'(sram_cs_a), 1);
    chk("a_restart_addr", 32'(addr_a), 0);
    tick();
    chk("a_restart_addr1", 32'(addr_a), 1);
    chk("a_restart_row",   32'(img_row_a), 0);
    state_a = 3'd0;

    // Instance B: base 32, latency 3, request toggling 0/1.
    state_b = 3'd1;
    for (int k = 1; k <= 21; k++) begin
      req_b = ((k % 2) == 0);
      tick();
      chk("b_cs",   32'(sram_cs_b), 32'((k % 2 == 0) && (k >= 2) && (k <= 16)));
      chk("b_addr", 32'(addr_b), (k < 2) ? 0 : 32 + (((k - 2) / 2 > 7) ? 7 : (k - 2) / 2));
      chk("b_valid", 32'(img_valid_b), 32'((k % 2 == 1) && (k >= 5) && (k <= 19)));
      e_row = (k < 5) ? 0 : (((k - 5) / 2 > 7) ? 7 : (k - 5) / 2);
      chk("b_row",  32'(img_row_b), e_row);
      chk("b_pass", 32'(img_pass_b), 0);
      chk("b_last", 32'(img_last_b), 32'(k == 19));
      chk("b_done", 32'(fetch_done_b), 32'(k == 20));
    end
    state_b = 3'd0;
    tick();
    chk("b_idle_addr", 32'(addr_b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
